// File: rtl/alu_serial_if.sv
// alu_serial_if: request/response handshake bundle for alu_serial.
// The overflow flag exists only when ALU_SERIAL_OVF_EN is defined.
interface alu_serial_if #(parameter int WIDTH = 32);
   logic in_valid, in_ready, out_valid, out_ready, cout, zero;
   logic [WIDTH-1:0] src1, src2, result;
   logic [3:0] alu_ctrl;
`ifdef ALU_SERIAL_OVF_EN
   logic overflow;
   modport master(output in_valid, src1, src2, alu_ctrl, out_ready,
                  input in_ready, out_valid, result, cout, zero, overflow);
   modport slave(input in_valid, src1, src2, alu_ctrl, out_ready,
                 output in_ready, out_valid, result, cout, zero, overflow);
`else
   modport master(output in_valid, src1, src2, alu_ctrl, out_ready,
                  input in_ready, out_valid, result, cout, zero);
   modport slave(input in_valid, src1, src2, alu_ctrl, out_ready,
                 output in_ready, out_valid, result, cout, zero);
`endif
endinterface

// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU, DIGIT bits per cycle LSD first, registered inter-digit carry.
// ALU_SERIAL_OVF_EN adds the overflow flag and makes SLT a true signed compare.
module alu_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input logic clk,
   input logic rst,
   alu_serial_if.slave bus
);
   localparam int N = WIDTH / DIGIT;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110, OP_NOR = 4'b1100, OP_SLT = 4'b0111;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a, b, merged, fin;
   logic [3:0] op;
   logic [CW-1:0] cnt;
   logic carry, cc, c_msb_in, c_out, ovf_raw, less, arith, last;
   logic [DIGIT-1:0] da, db, s, dres;
   int sh;
   always_comb begin
      arith = op == OP_ADD || op == OP_SUB || op == OP_SLT;
      last = cnt == CW'(N - 1);
      sh = int'(cnt) * DIGIT;
      da = DIGIT'(a >> sh) ^ {DIGIT{op == OP_NOR}};
      db = DIGIT'(b >> sh) ^ {DIGIT{op == OP_SUB || op == OP_SLT || op == OP_NOR}};
      s = '0;
      cc = carry;
      c_msb_in = carry;
      for (int i = 0; i < DIGIT; i++) begin
         s[i] = da[i] ^ db[i] ^ cc;
         c_msb_in = cc;
         cc = (da[i] & db[i]) | (cc & (da[i] ^ db[i]));
      end
      c_out = cc;
      ovf_raw = c_msb_in ^ c_out;
`ifdef ALU_SERIAL_OVF_EN
      less = s[DIGIT-1] ^ ovf_raw;
`else
      less = s[DIGIT-1];
`endif
      // NOR reaches here as AND of the inverted operands
      dres = (op == OP_AND || op == OP_NOR) ? da & db :
             op == OP_OR ? da | db :
             arith ? s : '0;
      merged = (bus.result & ~(WIDTH'({DIGIT{1'b1}}) << sh)) | (WIDTH'(dres) << sh);
      fin = op == OP_SLT ? WIDTH'(less) : merged;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         a <= '0;
         b <= '0;
         op <= '0;
         cnt <= '0;
         carry <= 1'b0;
         bus.in_ready <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.result <= '0;
         bus.cout <= 1'b0;
         bus.zero <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
         bus.overflow <= 1'b0;
`endif
      end else
         case (state)
            IDLE:
               if (bus.in_valid) begin
                  a <= bus.src1;
                  b <= bus.src2;
                  op <= bus.alu_ctrl;
                  cnt <= '0;
                  carry <= bus.alu_ctrl == OP_SUB || bus.alu_ctrl == OP_SLT;
                  bus.in_ready <= 1'b0;
                  state <= RUN;
               end
            RUN: begin
               carry <= c_out;
               cnt <= last ? cnt : cnt + 1'b1;
               bus.result <= last ? fin : merged;
               if (last) begin
                  bus.cout <= arith & c_out;
                  bus.zero <= fin == '0;
`ifdef ALU_SERIAL_OVF_EN
                  bus.overflow <= (op == OP_ADD || op == OP_SUB) & ovf_raw;
`endif
                  bus.out_valid <= 1'b1;
                  state <= DONE;
               end
            end
            DONE:
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready <= 1'b1;
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed checks of alu_serial at WIDTH=32, DIGIT=4.
// Flag expectations follow ALU_SERIAL_OVF_EN when it is defined for the build.
module tb_alu_serial;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   int cyc;
   alu_serial_if #(.WIDTH(32)) bus();
   alu_serial #(.WIDTH(32), .DIGIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // accept one operation, scramble the inputs, then count cycles to out_valid
   task automatic start(input logic [3:0] ctrl, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      chk("in_ready_idle", bus.in_ready, 1);
      bus.alu_ctrl = ctrl;
      bus.src1 = x;
      bus.src2 = y;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.src1 = ~x;
      bus.src2 = 32'h1234_5678;
      bus.alu_ctrl = 4'b0001;
      cyc = 0;
      while (!bus.out_valid && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("out_valid_seen", bus.out_valid, 1);
   endtask
   task automatic handoff;
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("out_valid_after_handoff", bus.out_valid, 0);
      chk("in_ready_after_handoff", bus.in_ready, 1);
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.src1 = '0;
      bus.src2 = '0;
      bus.alu_ctrl = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_cout", bus.cout, 0);
      chk("rst_zero", bus.zero, 0);
`ifdef ALU_SERIAL_OVF_EN
      chk("rst_overflow", bus.overflow, 0);
`endif
      @(negedge clk);
      rst = 1'b0;
      start(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
      chk("add_latency", cyc, 8);
      chk("add_result", bus.result, 32'h0);
      chk("add_cout", bus.cout, 1);
      chk("add_zero", bus.zero, 1);
      chk("add_in_ready_done", bus.in_ready, 0);
`ifdef ALU_SERIAL_OVF_EN
      chk("add_overflow", bus.overflow, 0);
`endif
      handoff();
      start(4'b0110, 32'h8000_0000, 32'h0000_0001);
      chk("sub_result", bus.result, 32'h7FFF_FFFF);
      chk("sub_cout", bus.cout, 1);
      chk("sub_zero", bus.zero, 0);
`ifdef ALU_SERIAL_OVF_EN
      chk("sub_overflow", bus.overflow, 1);
`endif
      handoff();
      start(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
      chk("slt_neg_result", bus.result, 32'h1);
      chk("slt_neg_zero", bus.zero, 0);
      handoff();
      start(4'b0111, 32'h8000_0000, 32'h7FFF_FFFF);
`ifdef ALU_SERIAL_OVF_EN
      chk("slt_ovf_result", bus.result, 32'h1);
      chk("slt_ovf_zero", bus.zero, 0);
      chk("slt_ovf_overflow", bus.overflow, 0);
`else
      chk("slt_ovf_result", bus.result, 32'h0);
      chk("slt_ovf_zero", bus.zero, 1);
`endif
      handoff();
      start(4'b1100, 32'h0F0F_0F0F, 32'h00FF_00FF);
      chk("nor_result", bus.result, 32'hF000_F000);
      chk("nor_cout", bus.cout, 0);
      handoff();
      start(4'b0000, 32'h0F0F_0F0F, 32'h00FF_00FF);
      chk("and_result", bus.result, 32'h000F_000F);
      handoff();
      start(4'b0001, 32'h0F0F_0F0F, 32'h00FF_00FF);
      chk("or_result", bus.result, 32'h0FFF_0FFF);
      chk("or_cout", bus.cout, 0);
      handoff();
      start(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("undef_latency", cyc, 8);
      chk("undef_result", bus.result, 32'h0);
      chk("undef_zero", bus.zero, 1);
      chk("undef_cout", bus.cout, 0);
      handoff();
      start(4'b0010, 32'h1234_5678, 32'h1111_1111);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_result", bus.result, 32'h2345_6789);
         chk("bp_in_ready", bus.in_ready, 0);
      end
      handoff();
      @(negedge clk);
      bus.alu_ctrl = 4'b0010;
      bus.src1 = 32'h0000_FFFF;
      bus.src2 = 32'h0000_0001;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rrst_out_valid", bus.out_valid, 0);
      chk("rrst_in_ready", bus.in_ready, 1);
      chk("rrst_result", bus.result, 0);
      chk("rrst_cout", bus.cout, 0);
      chk("rrst_zero", bus.zero, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("rrst_no_stale_valid", bus.out_valid, 0);
      start(4'b0010, 32'd5, 32'd7);
      chk("post_rst_latency", cyc, 8);
      chk("post_rst_result", bus.result, 32'd12);
      chk("post_rst_zero", bus.zero, 0);
      handoff();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_serial.md
# alu_serial

Parametrised digit-serial ALU: processes a WIDTH-bit operation DIGIT bits per clock, least significant digit first, through a chain of DIGIT 1-bit slices with a registered carry between cycles. It replaces the single-bit slice chain in the datapath wherever area matters more than latency. Operands are accepted and results returned over valid/ready handshakes. Carry-out, zero and overflow flags are produced alongside the result.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. N = WIDTH/DIGIT.

- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation.
- src1  input  WIDTH  operand A.
- src2  input  WIDTH  operand B.
- alu_ctrl  input  4  operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0111 SLT.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- cout  output  1  carry out of MSB.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow; present only with ALU_SERIAL_OVF_EN.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid, latch src1, src2 and alu_ctrl. Set digit counter to 0. Load carry = 1 for SUB/SLT, else 0. Go to RUN. Input changes after acceptance are ignored.
- RUN: each cycle, process digit counter k, i.e. bits [k·DIGIT +: DIGIT].
  - A_invert = 1 for NOR only. B_invert = 1 for SUB, SLT and NOR.
  - Per bit: AND/OR/NOR use (a^Ainv) & or | (b^Binv); ADD/SUB/SLT use a full adder.
  - The digit's carry out is registered as the next digit's carry in.
  - Result digit is written into result[k·DIGIT +: DIGIT].
  - After digit N-1, go to DONE.
- SLT: signed comparison. result = {WIDTH-1 zeros, less}, where less = sum[MSB] XOR overflow_raw.
- cout: final MSB carry for ADD/SUB/SLT; 0 for AND/OR/NOR.
- overflow: (carry into MSB) XOR (carry out of MSB) for ADD/SUB; 0 otherwise.
- zero: computed on the final result, including the SLT result.
- Undefined alu_ctrl: still takes N cycles; result=0, cout=0, overflow=0, zero=1.
- DONE: out_valid=1 and in_ready=0. result and flags are held stable until out_ready=1, then go to IDLE.
  - No new operation is accepted in the same cycle as result handoff.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, cout=0, zero=0, overflow=0.
- Reset asserted in any state aborts the operation immediately. No stale out_valid follows.
- Latency: acceptance at edge t; out_valid high after edge t+N.
  - N=1 gives a one-cycle turnaround through RUN.
- Throughput: one operation per N+2 cycles minimum, with out_ready held high.
- result/flags may change during RUN. They are guaranteed only while out_valid=1.
- The digit counter is ceil(log2 N) bits wide (minimum 1) and never wraps past N-1.

## Configuration
- ALU_SERIAL_OVF_EN defined: overflow port exists and is driven as above.
  - SLT uses the overflow-corrected less, giving a true signed comparison.
- ALU_SERIAL_OVF_EN undefined: the overflow port and its logic are removed.
  - SLT uses the raw MSB sum bit, i.e. less = sum[MSB]. This is incorrect when the subtraction overflows; this is intended.

## Test plan
WIDTH=32, DIGIT=4 throughout.
- ADD 0xFFFFFFFF + 0x00000001 → result=0, cout=1, zero=1, overflow=0; out_valid exactly 8 cycles after the accept edge.
- SUB 0x80000000 − 0x00000001 → result=0x7FFFFFFF, cout=1, overflow=1 (OVF_EN), zero=0.
- SLT 0xFFFFFFFF vs 0x00000001 → result=1. SLT 0x80000000 vs 0x7FFFFFFF → result=1 with OVF_EN, 0 without.
- NOR 0x0F0F0F0F, 0x00FF00FF → result=0xF000F000, cout=0. AND and OR on the same operands → 0x000F000F and 0x0FFF0FFF.
- Backpressure: out_ready low for 5 cycles in DONE → out_valid and result held constant and in_ready=0; handoff on the first out_ready=1 edge, then in_ready=1.
- Reset at RUN digit 3 → next cycle out_valid=0, in_ready=1, all outputs 0; a subsequent ADD 5+7 returns 12 normally.
